// File: rtl/bin_search_ctrl_pkg.sv
// bin_search_ctrl_pkg: shared state encoding, default width and midpoint helper for the search controller
package bin_search_ctrl_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE, FAIL} state_t;
  function automatic logic [31:0] mid(input logic [31:0] lo, input logic [31:0] hi);
    return lo + ((hi - lo) >> 1);
  endfunction
endpackage

// File: rtl/bin_search_ctrl.sv
// bin_search_ctrl: binary-searches comparator input A by driving probe on B from g/l/e flags, reporting found value and probe count
module bin_search_ctrl
  import bin_search_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = $clog2(WIDTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [WIDTH-1:0]  probe,
  input  logic              g,
  input  logic              l,
  input  logic              e,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  found,
  output logic [STEP_W-1:0] steps
);
  localparam logic [WIDTH-1:0] MAX = '1;
  state_t state;
  logic [WIDTH-1:0] lo, hi;
  logic [31:0] nlo, nhi;
  logic bad;
  always_comb begin
    nlo = g ? 32'(probe) + 32'd1 : 32'(lo);
    nhi = l ? 32'(probe) - 32'd1 : 32'(hi);
    bad = !$onehot({g, l, e}) || (g && probe == MAX) || (l && probe == '0) || (nlo > nhi);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      probe <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      found <= '0;
      steps <= '0;
      lo    <= '0;
      hi    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          lo    <= '0;
          hi    <= MAX;
          probe <= WIDTH'(mid(32'd0, 32'(MAX)));
          steps <= '0;
          busy  <= 1'b1;
          state <= SEARCH;
        end
        SEARCH: begin
          steps <= steps + 1'b1;
          if ($onehot({g, l, e}) && e) begin
            found <= probe;
            state <= DONE;
          end else if (bad) begin
            state <= FAIL;
          end else begin
            lo    <= nlo[WIDTH-1:0];
            hi    <= nhi[WIDTH-1:0];
            probe <= WIDTH'(mid(nlo, nhi));
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
